// File: rtl/cnn_pkg.sv
// Shared types and constants for the feature-map drain path.
package cnn_pkg;

   // Default stream word width: one IEEE-754 single-precision bit pattern.
   localparam int WORD_W = 32;

   // Drain controller states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Counter/address width for n distinct values, never narrower than 1 bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_2.sv
// Two-entry FIFO with a combinational head. A pop and a push in the same
// cycle are both honoured, even when full, so occupancy stays constant.
module fifo_2 #(
   parameter int DW_p = 34
) (
   input  logic            clk_i,
   input  logic            reset_n_i,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [DW_p-1:0] din_i,
   output logic [DW_p-1:0] dout_o,
   output logic            full_o,
   output logic            empty_o
);

   logic [DW_p-1:0] mem_reg [2];
   logic            wr_ptr_reg;
   logic            rd_ptr_reg;
   logic [1:0]      count_reg;
   logic            do_push;
   logic            do_pop;

   assign full_o  = (count_reg == 2'd2);
   assign empty_o = (count_reg == 2'd0);
   assign do_pop  = pop_i && !empty_o;
   // When full, a push is only taken if the head is leaving this same cycle.
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o  = mem_reg[rd_ptr_reg];

   // Storage write; cleared on reset so the head reads as zero.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mem_reg[0] <= '0;
         mem_reg[1] <= '0;
      end else if (do_push) begin
         mem_reg[wr_ptr_reg] <= din_i;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_reg <= !wr_ptr_reg;
         if (do_pop)  rd_ptr_reg <= !rd_ptr_reg;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/fm_drain.sv
// Drains M_p output feature maps from a buffer with one-cycle read latency
// into a ready/valid stream. A two-credit scheme bounds reads in flight plus
// FIFO occupancy at two, so the FIFO can never overflow while still
// sustaining one word per cycle under continuous ready.
module fm_drain
   import cnn_pkg::*;
#(
   parameter int M_p = 4,
   parameter int R_p = 16,
   parameter int C_p = 16,
   parameter int W_p = WORD_W,
   localparam int N_WORDS = M_p * R_p * C_p,
   localparam int AW = clog2_min1(N_WORDS)
) (
   input  logic           clk_i,
   input  logic           reset_n_i,
   input  logic           start_i,
   output logic           rd_en_o,
   output logic [AW-1:0]  rd_addr_o,
   input  logic [W_p-1:0] rd_data_i,
   output logic [W_p-1:0] data_o,
   output logic           valid_o,
   input  logic           ready_i,
   output logic           eom_o,
   output logic           last_o,
   output logic           done_o,
   output logic           busy_o
);

   localparam int RW = clog2_min1(R_p);
   localparam int CW = clog2_min1(C_p);
   localparam logic [AW-1:0] LAST_ADDR = AW'(N_WORDS - 1);
   localparam logic [RW-1:0] LAST_ROW  = RW'(R_p - 1);
   localparam logic [CW-1:0] LAST_COL  = CW'(C_p - 1);

   generate
      if (M_p < 1 || R_p < 1 || C_p < 1) begin : g_bad_dims
         $error("fm_drain: M_p, R_p and C_p must all be >= 1");
      end
   endgenerate

   state_t          state_reg;
   logic            busy_reg;
   logic            done_reg;
   logic [AW-1:0]   addr_reg;
   logic [RW-1:0]   row_reg;
   logic [CW-1:0]   col_reg;
   logic [1:0]      credit_reg;
   logic            pend_reg;
   logic [1:0]      tag_reg;

   logic            valid;
   logic            hs;
   logic            issue;
   logic            eom_now;
   logic            last_now;
   logic            fifo_full;
   logic            fifo_empty;
   logic [W_p+1:0]  fifo_din;
   logic [W_p+1:0]  fifo_dout;

   assign valid    = !fifo_empty;
   assign hs       = valid && ready_i;
   // A handshake this cycle frees a slot, so it can fund a read even at zero credits.
   assign issue    = (state_reg == ST_BUSY) && ((credit_reg != 2'd0) || hs);
   assign eom_now  = (row_reg == LAST_ROW) && (col_reg == LAST_COL);
   assign last_now = (addr_reg == LAST_ADDR);

   assign rd_en_o   = issue;
   assign rd_addr_o = addr_reg;
   assign valid_o   = valid;
   assign data_o    = fifo_dout[W_p-1:0];
   assign eom_o     = valid && fifo_dout[W_p+1];
   assign last_o    = valid && fifo_dout[W_p];
   assign done_o    = done_reg;
   assign busy_o    = busy_reg;

   // Read data lands one cycle after the strobe; its tags ride along from issue time.
   assign fifo_din = {tag_reg, rd_data_i};

   fifo_2 #(.DW_p(W_p + 2)) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (pend_reg),
      .pop_i     (hs),
      .din_i     (fifo_din),
      .dout_o    (fifo_dout),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   // Control FSM with address walk (column innermost, then row; map follows linearly).
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_reg <= ST_IDLE;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         addr_reg  <= '0;
         row_reg   <= '0;
         col_reg   <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start_i) begin
                  state_reg <= ST_BUSY;
                  busy_reg  <= 1'b1;
                  addr_reg  <= '0;
                  row_reg   <= '0;
                  col_reg   <= '0;
               end
            end
            ST_BUSY: begin
               if (issue) begin
                  if (last_now) begin
                     state_reg <= ST_FLUSH;
                  end else begin
                     addr_reg <= addr_reg + AW'(1);
                     if (col_reg == LAST_COL) begin
                        col_reg <= '0;
                        row_reg <= (row_reg == LAST_ROW) ? '0 : row_reg + RW'(1);
                     end else begin
                        col_reg <= col_reg + CW'(1);
                     end
                  end
               end
            end
            ST_FLUSH: begin
               if (hs && last_o) begin
                  state_reg <= ST_DONE;
                  done_reg  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   // Credit accounting and the one-cycle read-return pipeline.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         credit_reg <= 2'd2;
         pend_reg   <= 1'b0;
         tag_reg    <= 2'b00;
      end else begin
         pend_reg <= issue;
         if (issue) tag_reg <= {eom_now, last_now};
         if (issue && !hs)      credit_reg <= credit_reg - 2'd1;
         else if (hs && !issue) credit_reg <= credit_reg + 2'd1;
      end
   end

   // The credit scheme guarantees a returning word always finds a free slot.
   always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(pend_reg && fifo_full && !hs));
      end
   end

endmodule

// File: tb/tb_fm_drain.sv
// Directed bench for fm_drain with 2x2x2 maps and a buffer holding a+100.
module tb_fm_drain;

   localparam int M  = 2;
   localparam int R  = 2;
   localparam int C  = 2;
   localparam int W  = 32;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          ready = 1'b0;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_data = '0;
   logic [W-1:0]  data;
   logic          valid;
   logic          eom;
   logic          last;
   logic          done;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fm_drain #(.M_p(M), .R_p(R), .C_p(C), .W_p(W)) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .start_i   (start),
      .rd_en_o   (rd_en),
      .rd_addr_o (rd_addr),
      .rd_data_i (rd_data),
      .data_o    (data),
      .valid_o   (valid),
      .ready_i   (ready),
      .eom_o     (eom),
      .last_o    (last),
      .done_o    (done),
      .busy_o    (busy)
   );

   // Buffer model: registered read, mem[a] = a + 100.
   always @(posedge clk) begin
      if (rd_en) rd_data <= 32'(rd_addr) + 32'd100;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_val({pfx, " rd_en"},   32'(rd_en),   0);
      check_val({pfx, " valid"},   32'(valid),   0);
      check_val({pfx, " eom"},     32'(eom),     0);
      check_val({pfx, " last"},    32'(last),    0);
      check_val({pfx, " done"},    32'(done),    0);
      check_val({pfx, " busy"},    32'(busy),    0);
      check_val({pfx, " rd_addr"}, 32'(rd_addr), 0);
      check_val({pfx, " data"},    data,         0);
   endtask

   // mode 0: ready high, cycle-exact; 1: ready alternating; 2: start pulsed in
   // BUSY and FLUSH; 3: last word stalled 5 cycles. abort_after>0 resets the
   // DUT once that many handshakes have completed.
   task automatic drain(input int mode, input int abort_after);
      int cyc, words, reads, hs_cnt, stall_cnt;
      bit exp_done, next_done, finished, aborted, prev_stall, hs_now;
      logic [31:0] prev_data;
      logic prev_eom, prev_last;
      cyc = 0; words = 0; reads = 0; hs_cnt = 0; stall_cnt = 0;
      exp_done = 0; finished = 0; aborted = 0; prev_stall = 0;
      prev_data = '0; prev_eom = 0; prev_last = 0;
      start = 1'b1;
      while (!finished && !aborted && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (abort_after > 0 && hs_cnt == abort_after) begin
            reset_n = 1'b0;
            start = 1'b0;
            #1;
            check_reset_outputs("abort");
            @(posedge clk); #1;
            reset_n = 1'b1;
            aborted = 1;
         end else begin
            start = (mode == 2 && (cyc == 2 || cyc == 9));
            case (mode)
               1:       ready = cyc[0];
               3:       ready = !(valid && last && stall_cnt < 5);
               default: ready = 1'b1;
            endcase
            #1;
            hs_now = valid && ready;
            check_val($sformatf("done_o c%0d", cyc), 32'(done), 32'(exp_done));
            check_val($sformatf("busy_o c%0d", cyc), 32'(busy), 1);
            if (mode == 0) begin
               check_val($sformatf("rd_en c%0d", cyc), 32'(rd_en), 32'(cyc <= 8));
               check_val($sformatf("valid c%0d", cyc), 32'(valid), 32'(cyc >= 3 && cyc <= 10));
            end
            if (exp_done) finished = 1;
            if (rd_en) begin
               check_val("rd_addr", 32'(rd_addr), 32'(reads));
               reads++;
            end
            if (prev_stall) begin
               check_val("hold valid", 32'(valid), 1);
               check_val("hold data", data, prev_data);
               check_val("hold eom", 32'(eom), 32'(prev_eom));
               check_val("hold last", 32'(last), 32'(prev_last));
            end
            if (valid) begin
               check_val($sformatf("data w%0d", words), data, 32'(words + 100));
               check_val($sformatf("eom w%0d", words), 32'(eom), 32'(words % 4 == 3));
               check_val($sformatf("last w%0d", words), 32'(last), 32'(words == 7));
            end
            if (mode == 3 && valid && last && !ready) stall_cnt++;
            next_done = 0;
            if (hs_now) begin
               hs_cnt++;
               words++;
               if (last) next_done = 1;
            end
            exp_done = next_done;
            check_val("outstanding<=2", 32'((reads - hs_cnt) <= 2), 1);
            prev_stall = valid && !ready;
            prev_data = data;
            prev_eom = eom;
            prev_last = last;
         end
      end
      start = 1'b0;
      if (!aborted) begin
         check_val("drain completes", 32'(finished), 1);
         check_val("word count", 32'(words), 8);
         check_val("read count", 32'(reads), 8);
         if (mode == 3) check_val("last stall cycles", 32'(stall_cnt), 5);
      end
      @(posedge clk); #2;
      check_val("idle busy", 32'(busy), 0);
      check_val("idle done", 32'(done), 0);
      check_val("idle rd_en", 32'(rd_en), 0);
      $display("drain mode=%0d abort=%0d cycles=%0d words=%0d reads=%0d", mode, abort_after, cyc, words, reads);
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      ready = 1'b0;
      #2;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset clocked");
      reset_n = 1'b1;
      @(posedge clk); #2;
      drain(0, 0);   // streaming
      drain(1, 0);   // backpressure
      drain(2, 0);   // start ignored
      drain(0, 4);   // reset mid-drain
      drain(0, 0);   // restart from 0
      drain(3, 0);   // last-word stall
      drain(0, 0);   // back-to-back after done
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fm_drain.md
FM_DRAIN -- requirements
Module: fm_drain

Interface
REQ-001 SHALL have parameter M_p, default 4: number of output feature maps.
REQ-002 SHALL have parameter R_p, default 16: rows per map.
REQ-003 SHALL have parameter C_p, default 16: columns per map.
REQ-004 SHALL have parameter W_p, default 32: word width, IEEE-754 single-precision bit pattern.
REQ-005 SHALL have port clk_i, input, 1: the only clock; all state on rising edge.
REQ-006 SHALL have port reset_n_i, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start_i, input, 1: compute-complete pulse that begins a drain.
REQ-008 SHALL have port rd_en_o, output, 1: read strobe to the output feature-map buffer.
REQ-009 SHALL have port rd_addr_o, output, AW = max(1, clog2(M_p*R_p*C_p)): word address, m*R_p*C_p + r*C_p + c.
REQ-010 SHALL have port rd_data_i, input, W_p: buffer read data, valid exactly one cycle after rd_en_o.
REQ-011 SHALL have port data_o, output, W_p: stream word.
REQ-012 SHALL have port valid_o, output, 1: stream word valid.
REQ-013 SHALL have port ready_i, input, 1: downstream accept.
REQ-014 SHALL have port eom_o, output, 1: current word is r=R_p-1, c=C_p-1 of its map.
REQ-015 SHALL have port last_o, output, 1: current word is the final word of the drain.
REQ-016 SHALL have port done_o, output, 1: one-cycle completion pulse.
REQ-017 SHALL have port busy_o, output, 1: high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, BUSY, FLUSH, DONE.
REQ-019 IDLE->BUSY SHALL occur on the edge where start_i=1; start_i SHALL be ignored in all other states.
REQ-020 In BUSY, rd_en_o SHALL be high iff credits != 0 or (valid_o && ready_i) in the same cycle.
REQ-021 Credits SHALL reset to 2, decrement per read, increment per handshake, and stay unchanged when both occur.
REQ-022 Addresses SHALL be issued in order: c innermost, then r, then m, starting at 0 and incrementing by 1 per read.
REQ-023 BUSY->FLUSH SHALL occur on the edge that issues address M_p*R_p*C_p-1.
REQ-024 FLUSH->DONE SHALL occur on the handshake of the last word; DONE->IDLE SHALL occur unconditionally on the next edge.
REQ-025 done_o SHALL be high only in DONE.
REQ-026 rd_data_i SHALL be captured into a 2-entry FIFO; data_o, valid_o, eom_o, and last_o SHALL be driven from the FIFO head.
REQ-027 FIFO overflow SHALL be impossible by construction; simultaneous push and pop SHALL keep occupancy constant.
REQ-028 data_o, eom_o, and last_o SHALL hold stable while valid_o=1 and ready_i=0.
REQ-029 valid_o SHALL NOT depend combinationally on ready_i.
REQ-030 Latency: start_i sampled at edge k SHALL give rd_en_o in cycle k+1 and the first valid_o in cycle k+3.
REQ-031 With ready_i held high, throughput SHALL be 1 word per cycle.
REQ-032 Words SHALL pass through bit-exact, with no arithmetic applied.

Reset
REQ-033 On reset_n_i=0, regardless of clock, the block SHALL enter IDLE, set credits to 2, empty the FIFO, and zero the address counters.
REQ-034 During reset, rd_en_o, valid_o, eom_o, last_o, done_o, and busy_o SHALL all be 0, and rd_addr_o and data_o SHALL be 0.
REQ-035 Reset mid-drain SHALL abort the drain; a later start_i SHALL restart from address 0.

Structure
REQ-036 Package cnn_pkg SHALL hold the state enum typedef and the word-width constant.
REQ-037 The 2-entry FIFO SHALL be a sub-module named fifo_2 with push/pop, full/empty, and an asynchronous active-low reset.
REQ-038 Parameters M_p, R_p, and C_p SHALL each be >= 1, enforced by an elaboration assertion.

Verification (M_p=2, R_p=2, C_p=2, mem[a]=a+100)
REQ-039 Scenario, streaming: start at edge k with ready_i=1 -> data_o 100..107 in cycles k+3..k+10; eom_o on 103 and 107; last_o on 107; done_o in cycle k+11.
REQ-040 Scenario, backpressure: ready_i alternating 1/0 -> all 8 words in order, none lost or duplicated; reads in flight plus FIFO occupancy never exceed 2; data_o stable while stalled.
REQ-041 Scenario, start ignored: start_i pulsed in BUSY and in FLUSH -> no restart, and exactly 8 words are delivered.
REQ-042 Scenario, reset mid-drain: reset_n_i low after the 4th handshake -> outputs are 0 immediately; a new start yields 100..107.
REQ-043 Scenario, last-word stall: ready_i=0 for 5 cycles on word 107 -> last_o held, and done_o fires only after the handshake.
REQ-044 Scenario, back-to-back drains: start_i in the cycle after done_o -> a second full 100..107 sequence.
